// File: rtl/cordic_scheduler.sv
// Round-robin front end for one shared pipelined CORDIC rotator: arbitrates
// requesters, registers the winner onto the rotator and routes results back by tag.
module cordic_scheduler #(
   parameter  int unsigned NUM_REQ        = 4,
   parameter  int unsigned INPUT_WIDTH    = 16,
   parameter  int unsigned ANGLE_WIDTH    = 32,
   parameter  int unsigned CORDIC_LATENCY = 16,
   localparam int unsigned OUT_W          = INPUT_WIDTH + 1,
   localparam int unsigned CNT_W          = $clog2(CORDIC_LATENCY + 2),
   localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
   input  logic                           CLK,
   input  logic                           RST_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_x,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_y,
   output logic [ANGLE_WIDTH-1:0]         cor_angle,
   output logic [INPUT_WIDTH-1:0]         cor_x,
   output logic [INPUT_WIDTH-1:0]         cor_y,
   input  logic [OUT_W-1:0]               cor_x_out,
   input  logic [OUT_W-1:0]               cor_y_out,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [OUT_W-1:0]               rsp_x,
   output logic [OUT_W-1:0]               rsp_y,
   input  logic                           pause,
   output logic                           drained,
   output logic [CNT_W-1:0]               in_flight
);

   localparam int unsigned MAX_FLIGHT = CORDIC_LATENCY + 1;

   typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

   state_t                    state_q, state_d;
   logic [ID_W-1:0]           ptr_q, ptr_d;
   logic [ID_W-1:0]           grant_id;
   logic                      grant_any;
   logic [ID_W-1:0]           scan_idx;
   logic                      issue_vld_q;
   logic [ID_W-1:0]           issue_id_q;
   logic [CORDIC_LATENCY-1:0] tag_vld_q;
   logic [ID_W-1:0]           tag_id_q [CORDIC_LATENCY];
   logic                      deliver;

   assign deliver = tag_vld_q[CORDIC_LATENCY-1];

   // Round-robin scan starting at ptr; only RUN may grant.
   always_comb begin
      req_ready = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      scan_idx  = '0;
      ptr_d     = ptr_q;
      if (state_q == RUN) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[scan_idx]) begin
               grant_any = 1'b1;
               grant_id  = scan_idx;
            end
         end
      end
      if (grant_any) begin
         req_ready[grant_id] = 1'b1;
         ptr_d               = ID_W'((32'(grant_id) + 1) % NUM_REQ);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (pause) state_d = DRAIN;
         DRAIN:   if (!pause) state_d = RUN;
                  else if (in_flight == '0) state_d = PAUSED;
         PAUSED:  if (!pause) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= RUN;
         ptr_q   <= '0;
         drained <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         drained <= (state_q == PAUSED);
      end
   end

   // Issue register: winner's operands, or zeros on an idle slot.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         cor_angle   <= '0;
         cor_x       <= '0;
         cor_y       <= '0;
         issue_vld_q <= 1'b0;
         issue_id_q  <= '0;
      end else if (grant_any) begin
         cor_angle   <= req_angle[32'(grant_id)*ANGLE_WIDTH +: ANGLE_WIDTH];
         cor_x       <= req_x[32'(grant_id)*INPUT_WIDTH +: INPUT_WIDTH];
         cor_y       <= req_y[32'(grant_id)*INPUT_WIDTH +: INPUT_WIDTH];
         issue_vld_q <= 1'b1;
         issue_id_q  <= grant_id;
      end else begin
         cor_angle   <= '0;
         cor_x       <= '0;
         cor_y       <= '0;
         issue_vld_q <= 1'b0;
         issue_id_q  <= '0;
      end
   end

   // Tag pipeline: the issue register plus CORDIC_LATENCY stages lines up with the rotator output.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         tag_vld_q <= '0;
         for (int unsigned k = 0; k < CORDIC_LATENCY; k++) tag_id_q[k] <= '0;
      end else begin
         tag_vld_q   <= {tag_vld_q[CORDIC_LATENCY-2:0], issue_vld_q};
         tag_id_q[0] <= issue_id_q;
         for (int unsigned k = 1; k < CORDIC_LATENCY; k++) tag_id_q[k] <= tag_id_q[k-1];
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         rsp_valid <= '0;
         rsp_x     <= '0;
         rsp_y     <= '0;
      end else if (deliver) begin
         rsp_valid <= NUM_REQ'(1) << tag_id_q[CORDIC_LATENCY-1];
         rsp_x     <= cor_x_out;
         rsp_y     <= cor_y_out;
      end else begin
         rsp_valid <= '0;
      end
   end

   // Saturating occupancy count of issued but undelivered operations.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         in_flight <= '0;
      end else if (grant_any && !deliver) begin
         if (in_flight != CNT_W'(MAX_FLIGHT)) in_flight <= in_flight + CNT_W'(1);
      end else if (deliver && !grant_any) begin
         if (in_flight != '0) in_flight <= in_flight - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized bench for cordic_scheduler: real-valued rotator stand-in plus a
// queue-based reference of arbitration, drain control and result delivery.
module tb_cordic_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned IW = 16;
   localparam int unsigned AW = 32;
   localparam int unsigned L  = 16;
   localparam int unsigned OW = IW + 1;
   localparam int unsigned CW = $clog2(L + 2);

   logic            CLK_tb = 1'b0;
   logic            rst_n_tb;
   logic [N-1:0]    req_valid, req_ready, rsp_valid;
   logic [N*AW-1:0] req_angle;
   logic [N*IW-1:0] req_x, req_y;
   logic [AW-1:0]   cor_angle;
   logic [IW-1:0]   cor_x, cor_y;
   logic [OW-1:0]   cor_x_out, cor_y_out, rsp_x, rsp_y;
   logic            pause, drained;
   logic [CW-1:0]   in_flight;

   always #5 CLK_tb = ~CLK_tb;

   cordic_scheduler #(.NUM_REQ(N), .INPUT_WIDTH(IW), .ANGLE_WIDTH(AW), .CORDIC_LATENCY(L)) dut (
      .CLK(CLK_tb), .RST_n(rst_n_tb),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_angle(req_angle), .req_x(req_x), .req_y(req_y),
      .cor_angle(cor_angle), .cor_x(cor_x), .cor_y(cor_y),
      .cor_x_out(cor_x_out), .cor_y_out(cor_y_out),
      .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
      .pause(pause), .drained(drained), .in_flight(in_flight)
   );

   // Ideal rotation with CORDIC gain, result packed as {x, y}.
   function automatic logic [2*OW-1:0] rot(input logic [AW-1:0] ang,
                                           input logic signed [IW-1:0] x,
                                           input logic signed [IW-1:0] y);
      real th, g, fx, fy;
      th = 2.0 * 3.14159265358979 * real'(ang) / 4294967296.0;
      g  = 1.646760258;
      fx = g * (real'(x) * $cos(th) - real'(y) * $sin(th));
      fy = g * (real'(x) * $sin(th) + real'(y) * $cos(th));
      return {OW'(int'(fx)), OW'(int'(fy))};
   endfunction

   // Free-running rotator stand-in, never reset.
   logic [2*OW-1:0] rpipe [L];
   initial for (int k = 0; k < L; k++) rpipe[k] = '0;
   always @(posedge CLK_tb) begin
      for (int k = L - 1; k > 0; k--) rpipe[k] <= rpipe[k-1];
      rpipe[0] <= rot(cor_angle, cor_x, cor_y);
   end
   assign cor_x_out = rpipe[L-1][2*OW-1:OW];
   assign cor_y_out = rpipe[L-1][OW-1:0];

   int cyc = 0;
   always @(posedge CLK_tb) cyc <= cyc + 1;

   typedef struct {
      int              due;
      int              id;
      logic [2*OW-1:0] xy;
   } rsp_t;
   rsp_t q[$];

   int            total = 0;
   int            bad   = 0;
   int            m_state, m_ptr, m_inflight;
   logic [N-1:0]  e_rsp_valid;
   logic [OW-1:0] e_rsp_x, e_rsp_y;
   logic          e_drained;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_state = 0; m_ptr = 0; m_inflight = 0;
      e_rsp_valid = '0; e_rsp_x = '0; e_rsp_y = '0; e_drained = 1'b0;
   endtask

   // One clock: drive at negedge, check, advance the reference, wait for next negedge.
   task automatic tick(input logic [N-1:0] v, input logic p, input bit rnd);
      int g, t;
      logic [N-1:0] exp_ready, nv;
      req_valid = v;
      pause     = p;
      if (rnd) begin
         for (int i = 0; i < N; i++) begin
            req_angle[i*AW +: AW] = AW'($urandom);
            t = int'($urandom_range(0, 38000)) - 19000;
            req_x[i*IW +: IW] = IW'(t);
            t = int'($urandom_range(0, 38000)) - 19000;
            req_y[i*IW +: IW] = IW'(t);
         end
      end
      #1;
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
      chk("rsp_x", 64'(rsp_x), 64'(e_rsp_x));
      chk("rsp_y", 64'(rsp_y), 64'(e_rsp_y));
      chk("in_flight", 64'(in_flight), 64'(m_inflight));
      chk("drained", 64'(drained), 64'(e_drained));
      g = -1;
      if (m_state == 0)
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_ready = (g >= 0) ? N'(1) << g : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (g >= 0) q.push_back('{cyc + L + 2, g,
                                rot(req_angle[g*AW +: AW], req_x[g*IW +: IW], req_y[g*IW +: IW])});
      nv = '0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
         nv      = N'(1) << q[0].id;
         e_rsp_x = q[0].xy[2*OW-1:OW];
         e_rsp_y = q[0].xy[OW-1:0];
         void'(q.pop_front());
      end
      e_drained = (m_state == 2);
      case (m_state)
         0: if (p) m_state = 1;
         1: if (!p) m_state = 0; else if (m_inflight == 0) m_state = 2;
         default: if (!p) m_state = 0;
      endcase
      m_inflight  = m_inflight + ((g >= 0) ? 1 : 0) - ((nv != '0) ? 1 : 0);
      e_rsp_valid = nv;
      if (g >= 0) m_ptr = (g + 1) % N;
      @(negedge CLK_tb);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_x"}, 64'(rsp_x), 64'(0));
      chk({tag, "_rsp_y"}, 64'(rsp_y), 64'(0));
      chk({tag, "_cor_angle"}, 64'(cor_angle), 64'(0));
      chk({tag, "_cor_x"}, 64'(cor_x), 64'(0));
      chk({tag, "_cor_y"}, 64'(cor_y), 64'(0));
      chk({tag, "_in_flight"}, 64'(in_flight), 64'(0));
      chk({tag, "_drained"}, 64'(drained), 64'(0));
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input int x, input int y);
      req_angle[i*AW +: AW] = a;
      req_x[i*IW +: IW]     = IW'(x);
      req_y[i*IW +: IW]     = IW'(y);
   endtask

   function automatic bit near(input logic [OW-1:0] val, input int target);
      int d;
      d = int'($signed(val)) - target;
      return (d <= 16 && d >= -16);
   endfunction

   logic p_rnd;

   initial begin
      rst_n_tb  = 1'b0;
      req_valid = '0; req_angle = '0; req_x = '0; req_y = '0; pause = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK_tb);
      #1 check_zero_outputs("rst");
      @(negedge CLK_tb);
      rst_n_tb = 1'b1;

      // single operation at angle 0
      set_req(0, 32'h0, 19429, 0);
      tick(4'b0001, 1'b0, 1'b0);
      repeat (20) tick(4'b0000, 1'b0, 1'b0);
      chk("mag0_x", 64'(near(rsp_x, 32000)), 64'(1));
      chk("mag0_y", 64'(near(rsp_y, 0)), 64'(1));

      // quarter turn on requester 2
      set_req(2, 32'h4000_0000, 19429, 0);
      tick(4'b0100, 1'b0, 1'b0);
      repeat (20) tick(4'b0000, 1'b0, 1'b0);
      chk("mag90_x", 64'(near(rsp_x, 0)), 64'(1));
      chk("mag90_y", 64'(near(rsp_y, 32000)), 64'(1));

      // full contention
      repeat (8) tick(4'b1111, 1'b0, 1'b1);
      repeat (20) tick(4'b0000, 1'b0, 1'b0);

      // random traffic with pause bursts
      p_rnd = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 29) == 0) p_rnd = ~p_rnd;
         tick(N'($urandom), p_rnd, 1'b1);
      end
      repeat (30) tick(4'b0000, 1'b0, 1'b0);

      // pause with a full pipeline, drain, then resume
      repeat (20) tick(4'b0010, 1'b0, 1'b1);
      for (int n = 0; n < 40 && !drained; n++) tick(4'b1111, 1'b1, 1'b1);
      chk("drain_reached", 64'(drained), 64'(1));
      chk("drain_empty", 64'(in_flight), 64'(0));
      repeat (3) tick(4'b1111, 1'b1, 1'b1);
      repeat (6) tick(4'b1111, 1'b0, 1'b1);
      repeat (20) tick(4'b0000, 1'b0, 1'b0);

      // 360-point sweep on requester 1
      for (int k = 0; k < 360; k++) begin
         set_req(1, AW'((64'(k) << 32) / 360), 19429, 0);
         tick(4'b0010, 1'b0, 1'b0);
      end
      repeat (20) tick(4'b0000, 1'b0, 1'b0);

      // reset with operations in flight
      repeat (10) tick(4'b1011, 1'b0, 1'b1);
      rst_n_tb  = 1'b0;
      req_valid = '0;
      pause     = 1'b0;
      #1 check_zero_outputs("midrst");
      model_reset();
      repeat (2) @(negedge CLK_tb);
      rst_n_tb = 1'b1;
      repeat (20) tick(4'b0000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
